// File: rtl/weight_mem_pkg.sv
// Shared sizes, FSM encoding and helpers for the weight memory sequencer.
// Imported by the sequencer top level and its output stage.
package weight_mem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 30;
    localparam int DEPTH  = 128;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_t;

    // A burst must move at least one word and never more than the whole memory.
    function automatic logic len_legal(input logic [CNT_W-1:0] len);
        return (len != '0) && (len <= CNT_W'(DEPTH));
    endfunction

endpackage

// File: rtl/wms_out_stage.sv
// Output register of the read stream: captures a memory word on each advance,
// or empties itself when the burst has nothing more to issue.
module wms_out_stage
    import weight_mem_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              adv_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (adv_i) begin
            if (load_i) begin
                valid_d = 1'b1;
                data_d  = data_i;
                last_d  = last_i;
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/weight_mem_sequencer.sv
// Owns both ports of one weight memory: streams host words in (LOAD) and
// streams a base/length burst out to the MAC datapath with valid/ready (READ).
module weight_mem_sequencer
    import weight_mem_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_base,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              burst_busy,
    output logic              burst_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  loaded_words,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_wr_address,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] mem_rd_address,
    input  logic [DATA_W-1:0] mem_rd_data
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  loaded_q, loaded_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic              err_q, err_d;

    logic              start_ok;
    logic              beat;
    logic [CNT_W-1:0]  cnt_inc;
    logic              adv;
    logic              more;

    assign start_ok   = burst_start && (state_q == ST_IDLE) && len_legal(burst_len);
    // A start request in IDLE wins over a host word offered in the same cycle.
    assign load_ready = (state_q == ST_LOAD) || ((state_q == ST_IDLE) && !burst_start);
    assign beat       = load_valid && load_ready;
    // The load count lives in 1..DEPTH, so the word after a full memory counts as 1.
    assign cnt_inc    = (load_cnt_q == CNT_W'(DEPTH)) ? CNT_W'(1) : load_cnt_q + CNT_W'(1);
    assign adv        = (state_q == ST_READ) && (!out_valid || out_ready);
    assign more       = issued_q < len_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        load_cnt_d = load_cnt_q;
        loaded_d   = loaded_q;
        len_d      = len_q;
        issued_d   = issued_q;
        err_d      = burst_start && !start_ok;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (start_ok) begin
                    state_d  = ST_READ;
                    rd_ptr_d = burst_base;
                    len_d    = burst_len;
                    issued_d = '0;
                end else if (beat) begin
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    load_cnt_d = cnt_inc;
                    state_d    = ST_LOAD;
                    if (load_last) begin
                        loaded_d   = cnt_inc;
                        wr_ptr_d   = '0;
                        load_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (adv) begin
                    if (more) begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        issued_d = issued_q + CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            load_cnt_q <= '0;
            loaded_q   <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            load_cnt_q <= load_cnt_d;
            loaded_q   <= loaded_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            err_q      <= err_d;
        end
    end

    wms_out_stage u_out_stage (
        .clk     (CLOCK_50),
        .srst    (RESET),
        .adv_i   (adv),
        .load_i  (more),
        .data_i  (mem_rd_data),
        .last_i  (issued_q == len_q - CNT_W'(1)),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last)
    );

    assign burst_busy     = (state_q == ST_READ);
    assign burst_err      = err_q;
    assign loaded_words   = loaded_q;
    assign mem_wr         = beat;
    assign mem_wr_address = wr_ptr_q;
    assign mem_wr_data    = load_data;
    assign mem_rd_address = rd_ptr_q;

endmodule
